// File: rtl/crc_engine_param.sv
// Parametrised CRC engine: one DATA_W-bit word per cycle, with framing, a per-frame latched
// result, a residue check, a saturating word counter and a protocol-error pulse.
module crc_engine_param #(
  parameter int unsigned CRC_W   = 32,
  parameter int unsigned DATA_W  = 8,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFIN   = 1'b1,
  parameter bit          REFOUT  = 1'b1,
  parameter logic [31:0] RESIDUE = 32'h2144DF1C,
  parameter int unsigned LEN_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              rx_we,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic [CRC_W-1:0]  tx_crc,
  output logic [CRC_W-1:0]  frame_crc,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_valid,
  output logic              crc_match,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  localparam logic [CRC_W-1:0] InitVal = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] PolyVal = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XorVal  = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] ResVal  = RESIDUE[CRC_W-1:0];

  function automatic logic [DATA_W-1:0] bitrev_data(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W); i++) r[i] = d[int'(DATA_W) - 1 - i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < int'(CRC_W); i++) r[i] = c[int'(CRC_W) - 1 - i];
    return r;
  endfunction

  // MSB-first polynomial division of the whole word in one combinational step.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] seed,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = seed;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ PolyVal;
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] finalise(input logic [CRC_W-1:0] c);
    return (REFOUT ? bitrev_crc(c) : c) ^ XorVal;
  endfunction

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   tx_crc_q, tx_crc_d;
  logic [CRC_W-1:0]   frame_crc_q, frame_crc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic               match_q, match_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               frame_start;
  logic [DATA_W-1:0]  data_in;
  logic [CRC_W-1:0]   crc_next;
  logic [LEN_W-1:0]   len_next;

  // Datapath: seed selection, word update and saturating length of the frame so far.
  always_comb begin
    data_in     = REFIN ? bitrev_data(rx_data) : rx_data;
    // Any word in IDLE starts a frame so that sof-less legacy streams still work.
    frame_start = rx_we && ((state_q == StIdle) || rx_sof);
    crc_next    = crc_step(frame_start ? InitVal : crc_q, data_in);
    if (frame_start)       len_next = LEN_W'(1);
    else if (&cnt_q)       len_next = cnt_q;
    else                   len_next = cnt_q + LEN_W'(1);
  end

  // Next-state: clear wins over rx_we; eof closes the frame regardless of state.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    frame_crc_d = frame_crc_q;
    frame_len_d = frame_len_q;
    match_d     = match_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    if (clear) begin
      state_d = StIdle;
      crc_d   = InitVal;
      cnt_d   = '0;
    end else if (rx_we) begin
      crc_d = crc_next;
      cnt_d = len_next;
      err_d = (state_q == StActive) && rx_sof;
      if (rx_eof) begin
        state_d     = StIdle;
        cnt_d       = '0;
        frame_crc_d = finalise(crc_next);
        frame_len_d = len_next;
        match_d     = (finalise(crc_next) == ResVal);
        valid_d     = 1'b1;
      end else begin
        state_d = StActive;
      end
    end
    tx_crc_d = finalise(crc_d);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      crc_q       <= InitVal;
      tx_crc_q    <= finalise(InitVal);
      cnt_q       <= '0;
      frame_crc_q <= '0;
      frame_len_q <= '0;
      match_q     <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      tx_crc_q    <= tx_crc_d;
      cnt_q       <= cnt_d;
      frame_crc_q <= frame_crc_d;
      frame_len_q <= frame_len_d;
      match_q     <= match_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign tx_crc      = tx_crc_q;
  assign frame_crc   = frame_crc_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = valid_q;
  assign crc_match   = match_q;
  assign frame_err   = err_q;
  assign busy        = (state_q == StActive);

endmodule

// File: tb/tb_crc_engine_param.sv
// Self-checking bench for crc_engine_param: default CRC-32 instance plus a CRC-16/CCITT-FALSE
// instance with a 3-bit length counter to reach saturation.
module tb_crc_engine_param;

  logic        clk = 1'b0;
  logic        reset, clear, rx_we, rx_we2, rx_sof, rx_eof;
  logic [7:0]  rx_data;

  logic [31:0] tx_crc, frame_crc;
  logic [15:0] frame_len;
  logic        frame_valid, crc_match, frame_err, busy;

  logic [15:0] tx_crc2, frame_crc2;
  logic [2:0]  frame_len2;
  logic        frame_valid2, crc_match2, frame_err2, busy2;

  crc_engine_param dut (
    .clk(clk), .reset(reset), .clear(clear), .rx_we(rx_we), .rx_data(rx_data),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .tx_crc(tx_crc), .frame_crc(frame_crc),
    .frame_len(frame_len), .frame_valid(frame_valid), .crc_match(crc_match),
    .frame_err(frame_err), .busy(busy)
  );

  crc_engine_param #(
    .CRC_W(16), .DATA_W(8), .POLY(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0),
    .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(32'h0), .LEN_W(3)
  ) dut16 (
    .clk(clk), .reset(reset), .clear(clear), .rx_we(rx_we2), .rx_data(rx_data),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .tx_crc(tx_crc2), .frame_crc(frame_crc2),
    .frame_len(frame_len2), .frame_valid(frame_valid2), .crc_match(crc_match2),
    .frame_err(frame_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] crc;
    logic [15:0] len;
    logic        match;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] txq[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         err_seen = 0;

  // Reflected LSB-first CRC-32 reference (register form, not yet complemented).
  function automatic logic [31:0] ref_upd(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] c;
    c = r ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Scoreboard consumer: every frame_valid pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (frame_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame_valid got crc=%h len=%0d, expected no frame",
                 frame_crc, frame_len);
      end else begin
        mon_e = sb.pop_front();
        if (frame_crc !== mon_e.crc || frame_len !== mon_e.len || crc_match !== mon_e.match) begin
          n_fail++;
          $display("FAIL frame_result got crc=%h len=%0d match=%b expected crc=%h len=%0d match=%b",
                   frame_crc, frame_len, crc_match, mon_e.crc, mon_e.len, mon_e.match);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    rx_we = 1'b0; rx_we2 = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic second);
    rx_we = !second; rx_we2 = second; rx_data = d; rx_sof = s; rx_eof = e;
    @(posedge clk);
    #1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
  endtask

  // Drives txq into the CRC-32 instance, modelling tx_crc and busy after every word.
  task automatic send_txq(input bit sof, input bit eof);
    logic [31:0] r;
    int          len;
    exp_t        e;
    logic        last;
    r   = 32'hFFFFFFFF;
    len = 0;
    for (int i = 0; i < txq.size(); i++) begin
      last = (i == txq.size() - 1);
      r    = ref_upd(r, txq[i]);
      len++;
      if (eof && last) begin
        e.crc   = ~r;
        e.len   = 16'(len);
        e.match = (~r == 32'h2144DF1C);
        sb.push_back(e);
      end
      drive(txq[i], sof && (i == 0), eof && last, 1'b0);
      n_checks++;
      if (tx_crc !== ~r) begin
        n_fail++;
        $display("FAIL tx_crc_running word %0d got %h expected %h", i, tx_crc, ~r);
      end
      n_checks++;
      if (busy !== !(eof && last)) begin
        n_fail++;
        $display("FAIL busy_running word %0d got %b expected %b", i, busy, !(eof && last));
      end
    end
    txq.delete();
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_frames_missing got %0d pending expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; clear = 1'b0;
    idle(3);
    n_checks++;
    if (tx_crc !== 32'h0 || frame_crc !== 32'h0 || frame_len !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values got tx=%h fcrc=%h len=%0d expected 0 0 0",
               tx_crc, frame_crc, frame_len);
    end
    n_checks++;
    if (frame_valid !== 1'b0 || crc_match !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b m=%b e=%b b=%b expected 0 0 0 0",
               frame_valid, crc_match, frame_err, busy);
    end
    n_checks++;
    if (tx_crc2 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_tx_crc16 got %h expected ffff", tx_crc2);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_check_string;
    push_str("123456789");
    send_txq(1'b1, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_crc !== 32'hCBF43926 || frame_len !== 16'd9) begin
      n_fail++;
      $display("FAIL check_string got v=%b crc=%h len=%0d expected 1 cbf43926 9",
               frame_valid, frame_crc, frame_len);
    end
    idle(1);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_valid_one_cycle got %b expected 0", frame_valid);
    end
    check_drained("check_string");
  endtask

  task automatic test_residue;
    push_str("123456789");
    txq.push_back(8'h26); txq.push_back(8'h39); txq.push_back(8'hF4); txq.push_back(8'hCB);
    send_txq(1'b1, 1'b1);
    n_checks++;
    if (frame_crc !== 32'h2144DF1C || crc_match !== 1'b1 || frame_len !== 16'd13) begin
      n_fail++;
      $display("FAIL residue got crc=%h match=%b len=%0d expected 2144df1c 1 13",
               frame_crc, crc_match, frame_len);
    end
    idle(2);
    check_drained("residue");
  endtask

  task automatic test_crc16_saturation;
    string s;
    s = "123456789";
    for (int i = 0; i < 9; i++) drive(s[i], i == 0, i == 8, 1'b1);
    n_checks++;
    if (frame_valid2 !== 1'b1 || frame_crc2 !== 16'h29B1 || crc_match2 !== 1'b0) begin
      n_fail++;
      $display("FAIL crc16 got v=%b crc=%h m=%b expected 1 29b1 0",
               frame_valid2, frame_crc2, crc_match2);
    end
    n_checks++;
    if (frame_len2 !== 3'd7) begin
      n_fail++;
      $display("FAIL len_saturate got %0d expected 7", frame_len2);
    end
    // Strobes without rx_we must be ignored by the idle CRC-32 instance.
    rx_we = 1'b0; rx_we2 = 1'b0; rx_sof = 1'b1; rx_eof = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx_crc !== 32'h2144DF1C) begin
      n_fail++;
      $display("FAIL ignored_strobes got busy=%b tx=%h expected 0 2144df1c", busy, tx_crc);
    end
    idle(1);
  endtask

  task automatic test_stream_and_clear;
    txq.push_back(8'hEF); txq.push_back(8'hBE); txq.push_back(8'hAD); txq.push_back(8'hDE);
    repeat (4) txq.push_back(8'h00);
    send_txq(1'b0, 1'b0);
    idle(2);
    check_drained("stream");
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_busy_hold got %b expected 1", busy);
    end
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    n_checks++;
    if (tx_crc !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle got tx=%h busy=%b expected 0 0", tx_crc, busy);
    end
  endtask

  task automatic test_back_to_back;
    int e0;
    push_str("123");
    send_txq(1'b1, 1'b1);
    push_str("4567");
    send_txq(1'b1, 1'b1);
    idle(1);
    e0 = err_seen;
    push_str("AB");
    send_txq(1'b1, 1'b0);
    push_str("123456789");
    send_txq(1'b1, 1'b1);
    idle(2);
    n_checks++;
    if (err_seen - e0 !== 1) begin
      n_fail++;
      $display("FAIL frame_err_pulses got %0d expected 1", err_seen - e0);
    end
    n_checks++;
    if (frame_crc !== 32'hCBF43926) begin
      n_fail++;
      $display("FAIL restart_crc got %h expected cbf43926", frame_crc);
    end
    check_drained("back_to_back");
  endtask

  task automatic test_reset_clear_midframe;
    push_str("1234");
    send_txq(1'b1, 1'b0);
    rx_we = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (tx_crc !== 32'h0 || frame_crc !== 32'h0 || frame_len !== 16'h0 || busy !== 1'b0 ||
        crc_match !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got tx=%h crc=%h len=%0d busy=%b m=%b expected all 0",
               tx_crc, frame_crc, frame_len, busy, crc_match);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    push_str("123456789");
    send_txq(1'b1, 1'b1);
    idle(1);
    push_str("12");
    send_txq(1'b1, 1'b0);
    // clear together with an eof word: the word is dropped and no frame is reported.
    clear = 1'b1;
    drive(8'h33, 1'b0, 1'b1, 1'b0);
    clear = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0 || tx_crc !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_priority got v=%b tx=%h busy=%b expected 0 0 0",
               frame_valid, tx_crc, busy);
    end
    n_checks++;
    if (frame_crc !== 32'hCBF43926 || frame_len !== 16'd9 || crc_match !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_retain got crc=%h len=%0d m=%b expected cbf43926 9 0",
               frame_crc, frame_len, crc_match);
    end
    idle(1);
    push_str("123456789");
    send_txq(1'b1, 1'b1);
    idle(2);
    check_drained("reset_clear");
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; rx_we = 1'b0; rx_we2 = 1'b0;
    rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
    test_reset();
    test_check_string();
    test_residue();
    test_crc16_saturation();
    test_stream_and_clear();
    test_back_to_back();
    test_reset_clear_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_engine_param.md
Name: crc_engine_param

Overview:
Parametrised successor to the fixed CRC-32 byte engine. It computes a configurable CRC (width, polynomial, init, reflection, output XOR) over a DATA_W-bit word stream in one cycle per word. Framing (start/end of frame) latches a per-frame result, checks it against a residue, counts words and flags protocol errors. It sits between MAC/UART receive datapaths and the CPU bus glue.

Parameters:
CRC_W, 32, CRC width in bits (8..32)
DATA_W, 8, input word width (1..64), processed as a single parallel step
POLY, 32'h04C11DB7, generator polynomial, normal form, low CRC_W bits used
INIT, 32'hFFFFFFFF, register seed at frame start and reset
XOR_OUT, 32'hFFFFFFFF, XOR applied to the finalised value
REFIN, 1, 1 = bit-reverse each input word before update
REFOUT, 1, 1 = bit-reverse register before XOR_OUT
RESIDUE, 32'h2144DF1C, finalised value expected after data plus appended CRC
LEN_W, 16, width of frame word counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort: register<=INIT, state IDLE, no frame_valid
rx_we  in  1  input word strobe
rx_data  in  DATA_W  input word
rx_sof  in  1  first word of frame (qualified by rx_we)
rx_eof  in  1  last word of frame (qualified by rx_we)
tx_crc  out  CRC_W  running finalised CRC (registered)
frame_crc  out  CRC_W  finalised CRC latched at end of frame
frame_len  out  LEN_W  words in last completed frame (saturating)
frame_valid  out  1  one-cycle pulse: frame_crc/frame_len/crc_match updated
crc_match  out  1  frame_crc == RESIDUE[CRC_W-1:0]
frame_err  out  1  one-cycle pulse: rx_sof received while ACTIVE
busy  out  1  high in ACTIVE

Behaviour:
- Reset (async): crc_reg=INIT; state IDLE; tx_crc=finalise(INIT) (0x00000000 for defaults); frame_crc=0, frame_len=0, frame_valid=0, crc_match=0, frame_err=0, busy=0; word counter 0.
- finalise(r) = (REFOUT ? bitrev_CRC_W(r) : r) ^ XOR_OUT.
- Update: next = step(seed, REFIN ? bitrev_DATA_W(rx_data) : rx_data), MSB-first polynomial division over DATA_W bits. seed = INIT if a frame starts this cycle, else crc_reg.
- States: IDLE, ACTIVE.
- IDLE + rx_we: frame starts (rx_sof optional, so legacy sof-less streams work); crc_reg<=step(INIT,...); counter<=1; go ACTIVE unless rx_eof.
- ACTIVE + rx_we & !rx_sof: crc_reg<=step(crc_reg,...); counter++ saturating at 2^LEN_W-1.
- ACTIVE + rx_we & rx_sof: frame_err pulses next cycle; current frame discarded with no frame_valid; new frame starts with this word from INIT.
- rx_we & rx_eof (any state, including a sof&eof single-word frame): next cycle frame_crc<=finalise(next), frame_len<=counter+1 (saturating), crc_match updated, frame_valid=1 for exactly one cycle; state IDLE.
- rx_eof or rx_sof without rx_we: ignored.
- tx_crc: cycle N+1 shows finalise of all words accepted through cycle N; it holds when rx_we=0.
- clear: has priority over rx_we in the same cycle; clears frame_valid/frame_err for that cycle; frame_crc, frame_len and crc_match retain their last values.
- Back-to-back frames: eof in cycle N and sof/rx_we in N+1 are both accepted without bubble.
- busy = (state==ACTIVE), registered.

Test Plan:
- Defaults, ASCII "123456789" as 9 bytes, sof on the first and eof on the last -> frame_valid pulse one cycle after the last byte, frame_crc=0xCBF43926, frame_len=9, crc_match=0.
- Same 9 bytes followed by 26 39 F4 CB (eof on CB), 13 words -> frame_crc=0x2144DF1C, crc_match=1, frame_len=13.
- CRC_W=16, POLY=0x1021, INIT=0xFFFF, REFIN=REFOUT=0, XOR_OUT=0, "123456789" -> frame_crc=0x29B1.
- Defaults, DATA_W=32, words 0x34333231, 0x38373635, then DATA_W=8 not applicable; instead byte stream EF BE AD DE 00 00 00 00 without sof/eof -> tx_crc updates every cycle, no frame_valid, busy=1 after the first byte.
- Two back-to-back frames, then sof mid-frame -> frame_err pulse, the aborted frame produces no frame_valid, and the new frame CRC is correct from INIT.
- Reset asserted mid-frame and clear asserted mid-frame -> outputs at reset values (tx_crc=0), or tx_crc=0 with no frame_valid; next frame "123456789" yields 0xCBF43926.
